mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative RV32M multiply/divide unit for the EX stage of the 5-stage pipeline. Accepts forwarded operands (post-forwarding op1/op2) with the instruction's func3 and destination register, computes one of the eight M-extension operations over a fixed number of cycles, and returns a 32-bit result with a one-cycle `done` pulse. The hazard unit uses `busy` to hold the pipeline.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `flush` in 1: abort the current operation (branch mispredict or pipeline flush).
- `func3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32: rs1 value, already forwarded.
- `op_b` in 32: rs2 value, already forwarded.
- `rd_in` in 5: destination register tag.
- `busy` out 1: high in CALC and DONE.
- `done` out 1: result-valid strobe.
- `result` out 32: operation result.
- `rd_out` out 5: tag captured with the accepted request.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: 32 iterations, 6-bit counter from 0 to 31.
  - DONE: result presented for 1 cycle.
- IDLE→CALC on `start & ~flush`. At that edge, capture `func3` and `rd_in`, and register the operand magnitudes:
  - |op_a| if the op treats rs1 as signed (MULH, MULHSU, DIV, REM), else op_a raw.
  - Same rule for op_b (MULH, DIV, REM signed).
  - Capture sign flags.
- Multiply uses radix-2 shift-add.
  - 64-bit accumulator; one multiplier bit per CALC cycle.
  - Final product is negated when the sign flags differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide uses restoring division on unsigned magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if sign_a ^ sign_b (signed ops).
  - Remainder is negated if sign_a (signed ops).
- CALC→DONE when counter = 31. Sign correction and result selection are registered into `result` at this edge.
- Fast path, detected in IDLE at the `start` edge; goes IDLE→DONE directly with no CALC:
  - Divide by zero (op_b = 0):
    - DIV/DIVU return 0xFFFFFFFF.
    - REM/REMU return op_a.
  - Signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF):
    - DIV returns 0x80000000.
    - REM returns 0.
- DONE→IDLE unconditionally at the next edge.
- `result` and `rd_out` hold their value until the next accepted `start`.
- `flush` in CALC or DONE → IDLE next edge. Registered `result`/`rd_out` are not updated by the aborted operation.
- `start` while `busy` is ignored; no queuing.
- All arithmetic is unsigned on magnitudes. |0x80000000| = 0x80000000 as an unsigned 32-bit value; no 33-bit operand is needed.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `busy` 0, `done` 0.
  - `result` 0x00000000, `rd_out` 0.
  - Internal accumulators 0.
- `busy` = (state != IDLE). Registered state decode, no combinational path from `start`.
- `done` = (state == DONE) & ~flush. This is the only combinational input→output path.
- Normal latency: `start` accepted at edge E0 → CALC E1..E32 → `done` high in the cycle after E32, i.e. 33 cycles after the request cycle.
- Throughput is 1 op per 34 cycles: the earliest next `start` is accepted at the edge ending DONE+1, because IDLE must be observed.
- Fast-path latency: `done` in the cycle immediately after the `start` edge.
- `flush` and `start` in the same IDLE cycle: `flush` wins, nothing is accepted.
- `rst` asserted mid-operation: immediate return to reset values, with no `done` pulse.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD (−3) → `done` exactly 33 cycles after `start`, `result`=0xFFFFFFEB, `rd_out`=`rd_in`. `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (−7), op_b=2 → 0xFFFFFFFD.
- REM with the same operands → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done` 1 cycle after `start`.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Abort and reset mid-operation:
  - `flush` at CALC cycle 10 → `busy` low next cycle, no `done`, `result` keeps the previous value.
  - A new `start` then completes normally.
  - `rst` pulse at CALC cycle 20 → all outputs at reset values immediately.
- `start` re-asserted every cycle during an operation with different operands → ignored; exactly one `done` per accepted op, carrying the first operands' result.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: request/response bundle between the EX stage and the
// iterative multiply/divide unit.
//   master (pipeline side): drives start, flush, func3, op_a, op_b, rd_in;
//                           observes busy, done, result, rd_out.
//   slave  (MDU side)     : the mirror image of master.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, func3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, func3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per cycle over 32 CALC cycles, on unsigned operand magnitudes. Signs are
// re-applied when the result is registered. Divide-by-zero and signed
// overflow bypass CALC and finish in one cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mdu_iterative_if.slave: start/flush/func3/op_a/op_b/rd_in in,
//          busy/done/result/rd_out out
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  mdu_iterative_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic [5:0]        cnt_r;
  logic [2:0]        func3_r;
  logic [4:0]        rd_tag_r;
  logic [XLEN-1:0]   mag_a_r;
  logic [XLEN-1:0]   mag_b_r;
  logic              sign_a_r;
  logic              sign_b_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   result_r;
  logic [4:0]        rd_out_r;

  logic              sign_a_s;
  logic              sign_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              fast_s;
  logic [XLEN-1:0]   fast_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN+1:0]   div_diff_s;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_s;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100, 3'b110: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic rs2_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b100, 3'b110: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Two's-complement negate when neg is set; |0x80000000| stays 0x80000000.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Operand decode at request time: sign flags, magnitudes, fast-path results
  always_comb begin
    sign_a_s   = rs1_signed(bus.func3) & bus.op_a[XLEN-1];
    sign_b_s   = rs2_signed(bus.func3) & bus.op_b[XLEN-1];
    mag_a_s    = neg32(bus.op_a, sign_a_s);
    mag_b_s    = neg32(bus.op_b, sign_b_s);
    div_zero_s = bus.func3[2] & (bus.op_b == 32'h0000_0000);
    div_ovf_s  = bus.func3[2] & ~bus.func3[0] &
                 (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
    fast_s     = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      fast_res_s = bus.func3[1] ? bus.op_a : 32'hFFFF_FFFF;
    end else begin
      fast_res_s = bus.func3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // One iteration step and the sign-corrected result of the final step
  always_comb begin
    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                 (acc_r[0] ? {1'b0, mag_a_r} : 33'd0);
    // Restoring divide: acc holds {remainder, remaining dividend / quotient}.
    // The shifted remainder can reach 33 bits, hence acc_r[63:31].
    div_diff_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, mag_b_r};
    if (func3_r[2]) begin
      if (div_diff_s[XLEN+1]) begin
        acc_nxt_s = {acc_r[2*XLEN-2:0], 1'b0};
      end else begin
        acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
    prod_s = neg64(acc_nxt_s, sign_a_r ^ sign_b_r);
    quo_s  = neg32(acc_nxt_s[XLEN-1:0], sign_a_r ^ sign_b_r);
    rem_s  = neg32(acc_nxt_s[2*XLEN-1:XLEN], sign_a_r);
    case (func3_r)
      3'b000:                 final_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_s = quo_s;
      3'b110, 3'b111:         final_s = rem_s;
      default:                final_s = quo_s;
    endcase
  end

  // FSM next-state logic; flush beats a same-cycle start in IDLE
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start & ~bus.flush) begin
          accept_s    = 1'b1;
          state_nxt_s = fast_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 6'd31) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: capture request, iterate, publish result only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= 6'd0;
      func3_r  <= 3'd0;
      rd_tag_r <= 5'd0;
      mag_a_r  <= 32'd0;
      mag_b_r  <= 32'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      acc_r    <= 64'd0;
      result_r <= 32'd0;
      rd_out_r <= 5'd0;
    end else if (accept_s) begin
      cnt_r    <= 6'd0;
      func3_r  <= bus.func3;
      rd_tag_r <= bus.rd_in;
      mag_a_r  <= mag_a_s;
      mag_b_r  <= mag_b_s;
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      // Multiply shifts the multiplier out of the low half; divide shifts
      // the dividend out of it.
      acc_r    <= bus.func3[2] ? {32'd0, mag_a_s} : {32'd0, mag_b_s};
      if (fast_s) begin
        result_r <= fast_res_s;
        rd_out_r <= bus.rd_in;
      end
    end else if ((state_r == ST_CALC) && !bus.flush) begin
      acc_r <= acc_nxt_s;
      if (cnt_r == 6'd31) begin
        cnt_r    <= 6'd0;
        result_r <= final_s;
        rd_out_r <= rd_tag_r;
      end else begin
        cnt_r <= cnt_r + 6'd1;
      end
    end
  end

  // Output decode; done is masked by a flush arriving during DONE
  always_comb begin
    bus.busy   = (state_r != ST_IDLE);
    bus.done   = (state_r == ST_DONE) & ~bus.flush;
    bus.result = result_r;
    bus.rd_out = rd_out_r;
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed self-checking bench for mdu_iterative.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_iterative_if bus ();

  mdu_iterative dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for done, check latency/busy/result/tag.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    int seen;
    bus.func3 = f3;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.rd_in = rd;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    seen = 0;
    while (seen == 0 && lat <= 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1;
      end else begin
        step();
        lat++;
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
    step();
    chk({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int any_done;
    int ndone;
    int dlat;
    logic [31:0] dres;
    logic [4:0]  drd;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = 3'd0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    bus.rd_in = 5'd0;
    step();
    step();
    chk("reset busy",   {31'd0, bus.busy}, 32'd0);
    chk("reset done",   {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'h0000_0000);
    chk("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
    rst = 1'b0;
    step();

    // Normal-latency multiplies and divides
    run_op("MUL",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
    run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33);
    run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33);
    run_op("DIVU",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        33);
    run_op("REMU",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         33);

    // Fast paths
    run_op("DIVU_by0", 3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    run_op("REMU_by0", 3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1);
    run_op("DIV_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("REM_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1);

    // Known result ahead of the flush test
    run_op("MUL_pre", 3'b000, 32'd6, 32'd7, 5'd21, 32'd42, 33);

    // Flush at CALC cycle 10
    bus.func3 = 3'b000;
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd5;
    bus.rd_in = 5'd22;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("flush pre busy", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush done", {31'd0, bus.done}, 32'd0);
    step();
    bus.flush = 1'b0;
    chk("flush busy",   {31'd0, bus.busy}, 32'd0);
    chk("flush result", bus.result, 32'd42);
    chk("flush rd_out", {27'd0, bus.rd_out}, 32'd21);
    any_done = 0;
    repeat (40) begin
      if (bus.done) any_done++;
      step();
    end
    chk("flush no_done", any_done, 0);

    // flush and start together in IDLE: nothing accepted
    bus.start = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start busy", {31'd0, bus.busy}, 32'd0);

    run_op("MUL_post", 3'b000, 32'd3, 32'd5, 5'd22, 32'd15, 33);

    // Reset at CALC cycle 20
    bus.func3 = 3'b101;
    bus.op_a  = 32'd1000;
    bus.op_b  = 32'd3;
    bus.rd_in = 5'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("rst busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst done",   {31'd0, bus.done}, 32'd0);
    chk("rst result", bus.result, 32'h0000_0000);
    chk("rst rd_out", {27'd0, bus.rd_out}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst busy", {31'd0, bus.busy}, 32'd0);

    // start held high with changing operands while busy: ignored
    bus.func3 = 3'b101;
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd7;
    bus.rd_in = 5'd3;
    bus.start = 1'b1;
    step();
    ndone = 0;
    dlat  = 0;
    dres  = 32'd0;
    drd   = 5'd0;
    for (int i = 1; i <= 45; i++) begin
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          dlat = i;
          dres = bus.result;
          drd  = bus.rd_out;
        end
        bus.start = 1'b0;
      end else if (bus.start) begin
        bus.func3 = 3'b000;
        bus.op_a  = 32'(i * 13 + 1);
        bus.op_b  = 32'(i + 2);
        bus.rd_in = 5'(i);
      end
      step();
    end
    bus.start = 1'b0;
    chk("restart ndone",  ndone, 1);
    chk("restart lat",    dlat, 33);
    chk("restart result", dres, 32'd14);
    chk("restart rd_out", {27'd0, drd}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
